// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer family.
package rr_mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Channel-index width; a 1-bit index is kept even for degenerate channel counts.
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Stateless round-robin arbiter: rotate requests past the last winner, pick the
// lowest set bit, then rotate the winning index back into channel numbering.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = ch_w(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] last,
    output logic [CH_W-1:0] gnt_idx,
    output logic            gnt_valid
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
    localparam logic [CH_W:0]   N_EXT   = (CH_W + 1)'(N_CH);

    logic [CH_W-1:0] w_start;
    logic [N_CH-1:0] w_rot;
    logic [CH_W-1:0] w_first;
    logic [CH_W:0]   w_sum;
    logic [CH_W:0]   w_wrap;

    // Highest priority goes to the channel just after the previous winner.
    assign w_start = (last >= LAST_CH) ? '0 : last + 1'b1;

    genvar gi, gj;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_rot
            logic [N_CH-1:0] w_cand;
            for (gj = 0; gj < N_CH; gj++) begin : g_cand
                assign w_cand[gj] = req[(gi + gj) % N_CH];
            end
            assign w_rot[gi] = w_cand[w_start];
        end
    endgenerate

    always_comb begin
        w_first = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_first = CH_W'(i);
            end
        end
    end

    assign w_sum     = {1'b0, w_first} + {1'b0, w_start};
    assign w_wrap    = w_sum - N_EXT;
    assign gnt_idx   = (w_sum >= N_EXT) ? w_wrap[CH_W-1:0] : w_sum[CH_W-1:0];
    assign gnt_valid = |req;

endmodule

// File: rtl/rr_stream_mux.sv
// N:1 valid/ready stream multiplexer with a single registered output stage.
// Channel choice comes from an external select or from a round-robin arbiter.
module rr_stream_mux
    import rr_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int MODE  = MODE_RR,
    parameter int CH_W  = ch_w(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    input  logic [CH_W-1:0]       sel,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [CH_W-1:0]       out_ch,
    input  logic                  out_ready
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [CH_W-1:0]  r_out_ch;
    logic [CH_W-1:0]  r_rr_last;

    logic             w_load_en;
    logic             w_sel_valid;
    logic [CH_W-1:0]  w_rr_idx;
    logic             w_rr_valid;
    logic [CH_W-1:0]  w_gnt_idx;
    logic             w_gnt_valid;
    logic             w_xfer;
    logic [N_CH-1:0]  w_ready;
    logic [WIDTH-1:0] w_mux;

    // The output stage accepts a new beat when empty or draining this cycle.
    assign w_load_en = !r_out_valid || out_ready;

    rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .req       (in_valid),
        .last      (r_rr_last),
        .gnt_idx   (w_rr_idx),
        .gnt_valid (w_rr_valid)
    );

    // An out-of-range select matches no channel and therefore grants nothing.
    always_comb begin
        w_sel_valid = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel == CH_W'(i)) begin
                w_sel_valid = in_valid[i];
            end
        end
    end

    assign w_gnt_idx   = (MODE == MODE_SEL) ? sel         : w_rr_idx;
    assign w_gnt_valid = (MODE == MODE_SEL) ? w_sel_valid : w_rr_valid;
    assign w_xfer      = w_load_en && w_gnt_valid;

    always_comb begin
        w_ready = '0;
        if (rst_n && w_xfer) begin
            for (int i = 0; i < N_CH; i++) begin
                w_ready[i] = (w_gnt_idx == CH_W'(i));
            end
        end
    end

    always_comb begin
        w_mux = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_gnt_idx == CH_W'(i)) begin
                w_mux = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // With no grant the stage empties but keeps the last data and channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_load_en) begin
            if (w_gnt_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_mux;
                r_out_ch    <= w_gnt_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last <= CH_W'(N_CH - 1);
        end else if ((MODE == MODE_RR) && w_xfer) begin
            r_rr_last <= w_gnt_idx;
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready));

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: one round-robin instance and one select-driven instance,
// checked against a queue of expected output beats.
module tb_rr_stream_mux;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
    } beat_t;

    logic        clk;
    logic        rst_n;

    logic [3:0]  rr_in_valid;
    logic [31:0] rr_in_data;
    logic [3:0]  rr_in_ready;
    logic [1:0]  rr_sel;
    logic        rr_out_valid;
    logic [7:0]  rr_out_data;
    logic [1:0]  rr_out_ch;
    logic        rr_out_ready;

    logic [3:0]  s_in_valid;
    logic [31:0] s_in_data;
    logic [3:0]  s_in_ready;
    logic [1:0]  s_sel;
    logic        s_out_valid;
    logic [7:0]  s_out_data;
    logic [1:0]  s_out_ch;
    logic        s_out_ready;

    int    checks;
    int    failures;
    beat_t exp_q[$];

    rr_stream_mux #(.N_CH(4), .WIDTH(8), .MODE(1)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rr_in_valid),
        .in_data   (rr_in_data),
        .in_ready  (rr_in_ready),
        .sel       (rr_sel),
        .out_valid (rr_out_valid),
        .out_data  (rr_out_data),
        .out_ch    (rr_out_ch),
        .out_ready (rr_out_ready)
    );

    rr_stream_mux #(.N_CH(4), .WIDTH(8), .MODE(0)) u_sel (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .in_data   (s_in_data),
        .in_ready  (s_in_ready),
        .sel       (s_sel),
        .out_valid (s_out_valid),
        .out_data  (s_out_data),
        .out_ch    (s_out_ch),
        .out_ready (s_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    function automatic logic [1:0] oh_idx(input logic [3:0] oh);
        oh_idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) oh_idx = 2'(i);
        end
    endfunction

    task automatic test_reset();
        rst_n        = 1'b0;
        rr_in_valid  = 4'hF;
        rr_in_data   = 32'h0;
        rr_sel       = 2'd0;
        rr_out_ready = 1'b1;
        s_in_valid   = 4'hF;
        s_in_data    = 32'h0;
        s_sel        = 2'd0;
        s_out_ready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rr_in_ready !== 4'h0 || s_in_ready !== 4'h0) begin
            failures++;
            $display("FAIL reset.in_ready got rr=%b sel=%b exp=0000", rr_in_ready, s_in_ready);
        end
        checks++;
        if (rr_out_valid !== 1'b0 || rr_out_ch !== 2'd0 || rr_out_data !== 8'h00) begin
            failures++;
            $display("FAIL reset.rr_out got v=%b ch=%0d d=%h exp v=0 ch=0 d=00", rr_out_valid, rr_out_ch, rr_out_data);
        end
        checks++;
        if (s_out_valid !== 1'b0 || s_out_ch !== 2'd0) begin
            failures++;
            $display("FAIL reset.sel_out got v=%b ch=%0d exp v=0 ch=0", s_out_valid, s_out_ch);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (rr_in_ready !== 4'b0001) begin
            failures++;
            $display("FAIL reset.first_grant got=%b exp=0001", rr_in_ready);
        end
        checks++;
        if (s_in_ready !== 4'b0001) begin
            failures++;
            $display("FAIL reset.sel_first_grant got=%b exp=0001", s_in_ready);
        end
        // Producers withdraw before any edge: nothing may be captured.
        rr_in_valid = 4'h0;
        s_in_valid  = 4'h0;
        @(posedge clk);
        #1;
        checks++;
        if (rr_out_valid !== 1'b0 || s_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset.withdrawn got rr_v=%b sel_v=%b exp 0/0", rr_out_valid, s_out_valid);
        end
        $display("txn reset done");
    endtask

    task automatic test_rr_all_valid();
        logic [3:0] v [6] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
        logic       r [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0] e [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0};
        logic [1:0] idx;
        rr_in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rr_in_valid  = v[k];
            rr_out_ready = r[k];
            #1;
            checks++;
            if (rr_in_ready !== e[k]) begin
                failures++;
                $display("FAIL rr_all.in_ready[%0d] got=%b exp=%b", k, rr_in_ready, e[k]);
            end
            if (exp_q.size() != 0 && r[k]) exp_q.delete(0);
            if (e[k] != 4'h0) begin
                idx = oh_idx(e[k]);
                exp_q.push_back('{idx, rr_in_data[int'(idx)*8 +: 8]});
            end
            @(posedge clk);
            #1;
            checks++;
            if (rr_out_valid !== (exp_q.size() != 0)) begin
                failures++;
                $display("FAIL rr_all.out_valid[%0d] got=%b exp=%b", k, rr_out_valid, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                checks++;
                if (rr_out_ch !== exp_q[0].ch || rr_out_data !== exp_q[0].data) begin
                    failures++;
                    $display("FAIL rr_all.beat[%0d] got ch=%0d d=%h exp ch=%0d d=%h", k, rr_out_ch, rr_out_data, exp_q[0].ch, exp_q[0].data);
                end
            end
            $display("txn rr_all k=%0d in_ready=%b out_v=%b out_ch=%0d out_d=%h", k, rr_in_ready, rr_out_valid, rr_out_ch, rr_out_data);
        end
    endtask

    task automatic test_rr_skip_idle();
        logic [3:0] v [6] = '{4'h4, 4'h0, 4'hA, 4'hA, 4'h0, 4'h0};
        logic       r [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0] e [6] = '{4'h4, 4'h0, 4'h8, 4'h2, 4'h0, 4'h0};
        logic [1:0] idx;
        rr_in_data = {8'h33, 8'h32, 8'h31, 8'h30};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rr_in_valid  = v[k];
            rr_out_ready = r[k];
            #1;
            checks++;
            if (rr_in_ready !== e[k]) begin
                failures++;
                $display("FAIL rr_skip.in_ready[%0d] got=%b exp=%b", k, rr_in_ready, e[k]);
            end
            if (exp_q.size() != 0 && r[k]) exp_q.delete(0);
            if (e[k] != 4'h0) begin
                idx = oh_idx(e[k]);
                exp_q.push_back('{idx, rr_in_data[int'(idx)*8 +: 8]});
            end
            @(posedge clk);
            #1;
            checks++;
            if (rr_out_valid !== (exp_q.size() != 0)) begin
                failures++;
                $display("FAIL rr_skip.out_valid[%0d] got=%b exp=%b", k, rr_out_valid, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                checks++;
                if (rr_out_ch !== exp_q[0].ch || rr_out_data !== exp_q[0].data) begin
                    failures++;
                    $display("FAIL rr_skip.beat[%0d] got ch=%0d d=%h exp ch=%0d d=%h", k, rr_out_ch, rr_out_data, exp_q[0].ch, exp_q[0].data);
                end
            end
            $display("txn rr_skip k=%0d in_ready=%b out_v=%b out_ch=%0d out_d=%h", k, rr_in_ready, rr_out_valid, rr_out_ch, rr_out_data);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] v [6] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
        logic       r [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] e [6] = '{4'h4, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0};
        logic [1:0] idx;
        rr_in_data = {8'h43, 8'h42, 8'h41, 8'h40};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rr_in_valid  = v[k];
            rr_out_ready = r[k];
            #1;
            checks++;
            if (rr_in_ready !== e[k]) begin
                failures++;
                $display("FAIL bp.in_ready[%0d] got=%b exp=%b", k, rr_in_ready, e[k]);
            end
            if (exp_q.size() != 0 && r[k]) exp_q.delete(0);
            if (e[k] != 4'h0) begin
                idx = oh_idx(e[k]);
                exp_q.push_back('{idx, rr_in_data[int'(idx)*8 +: 8]});
            end
            @(posedge clk);
            #1;
            checks++;
            if (rr_out_valid !== (exp_q.size() != 0)) begin
                failures++;
                $display("FAIL bp.out_valid[%0d] got=%b exp=%b", k, rr_out_valid, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                checks++;
                if (rr_out_ch !== exp_q[0].ch || rr_out_data !== exp_q[0].data) begin
                    failures++;
                    $display("FAIL bp.beat[%0d] got ch=%0d d=%h exp ch=%0d d=%h", k, rr_out_ch, rr_out_data, exp_q[0].ch, exp_q[0].data);
                end
            end
            $display("txn bp k=%0d out_ready=%b in_ready=%b out_v=%b out_ch=%0d out_d=%h", k, r[k], rr_in_ready, rr_out_valid, rr_out_ch, rr_out_data);
        end
    endtask

    task automatic test_mode_sel();
        logic [1:0] sv [6] = '{2'd1, 2'd1, 2'd3, 2'd0, 2'd0, 2'd2};
        logic [3:0] v  [6] = '{4'h2, 4'h1, 4'h9, 4'hF, 4'hF, 4'h0};
        logic       r  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] e  [6] = '{4'h2, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};
        logic [1:0] idx;
        s_in_data = {8'h13, 8'h12, 8'h5C, 8'h10};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            s_sel       = sv[k];
            s_in_valid  = v[k];
            s_out_ready = r[k];
            #1;
            checks++;
            if (s_in_ready !== e[k]) begin
                failures++;
                $display("FAIL sel.in_ready[%0d] got=%b exp=%b", k, s_in_ready, e[k]);
            end
            if (exp_q.size() != 0 && r[k]) exp_q.delete(0);
            if (e[k] != 4'h0) begin
                idx = oh_idx(e[k]);
                exp_q.push_back('{idx, s_in_data[int'(idx)*8 +: 8]});
            end
            @(posedge clk);
            #1;
            checks++;
            if (s_out_valid !== (exp_q.size() != 0)) begin
                failures++;
                $display("FAIL sel.out_valid[%0d] got=%b exp=%b", k, s_out_valid, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                checks++;
                if (s_out_ch !== exp_q[0].ch || s_out_data !== exp_q[0].data) begin
                    failures++;
                    $display("FAIL sel.beat[%0d] got ch=%0d d=%h exp ch=%0d d=%h", k, s_out_ch, s_out_data, exp_q[0].ch, exp_q[0].data);
                end
            end
            $display("txn sel k=%0d sel=%0d in_ready=%b out_v=%b out_ch=%0d out_d=%h", k, sv[k], s_in_ready, s_out_valid, s_out_ch, s_out_data);
        end
    endtask

    task automatic test_reset_mid_stream();
        rr_in_data = {8'h63, 8'h62, 8'h61, 8'h60};
        @(negedge clk);
        rr_in_valid  = 4'hF;
        rr_out_ready = 1'b1;
        #1;
        checks++;
        if (rr_in_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rst_mid.pre_grant got=%b exp=0001", rr_in_ready);
        end
        exp_q.push_back('{2'd0, 8'h60});
        @(posedge clk);
        #1;
        @(negedge clk);
        rr_out_ready = 1'b0;
        #1;
        checks++;
        if (rr_in_ready !== 4'h0 || rr_out_valid !== 1'b1 || rr_out_data !== exp_q[0].data) begin
            failures++;
            $display("FAIL rst_mid.stalled got rdy=%b v=%b d=%h exp rdy=0000 v=1 d=%h", rr_in_ready, rr_out_valid, rr_out_data, exp_q[0].data);
        end
        // Reset lands between edges; it must take effect without a clock.
        #2;
        rr_out_ready = 1'b1;
        rst_n        = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if (rr_out_valid !== 1'b0 || rr_out_data !== 8'h00 || rr_out_ch !== 2'd0) begin
            failures++;
            $display("FAIL rst_mid.async_clear got v=%b d=%h ch=%0d exp v=0 d=00 ch=0", rr_out_valid, rr_out_data, rr_out_ch);
        end
        checks++;
        if (rr_in_ready !== 4'h0) begin
            failures++;
            $display("FAIL rst_mid.in_ready_in_reset got=%b exp=0000", rr_in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (rr_in_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rst_mid.restart_grant got=%b exp=0001", rr_in_ready);
        end
        exp_q.push_back('{2'd0, 8'h60});
        @(posedge clk);
        #1;
        checks++;
        if (rr_out_valid !== 1'b1 || rr_out_ch !== exp_q[0].ch || rr_out_data !== exp_q[0].data) begin
            failures++;
            $display("FAIL rst_mid.restart_beat got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h", rr_out_valid, rr_out_ch, rr_out_data, exp_q[0].ch, exp_q[0].data);
        end
        @(negedge clk);
        rr_in_valid = 4'h0;
        exp_q.delete(0);
        @(posedge clk);
        #1;
        checks++;
        if (rr_out_valid !== (exp_q.size() != 0)) begin
            failures++;
            $display("FAIL rst_mid.drain got v=%b exp=0", rr_out_valid);
        end
        $display("txn rst_mid done out_v=%b", rr_out_valid);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_rr_all_valid();
        test_rr_skip_idle();
        test_backpressure();
        test_mode_sel();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
